// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car SCAN elevator controller with latched car/hall calls and timed travel/dwell
module elevator_ctrl #(
    parameter int NUM_FLOORS    = 5,
    parameter int TRAVEL_CYCLES = 13000000,
    parameter int DWELL_CYCLES  = 13000000,
    parameter int RESET_FLOOR   = 0,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  car_req_valid,
    input  logic [FW-1:0]         car_req_floor,
    input  logic                  hall_req_valid,
    input  logic [FW-1:0]         hall_req_floor,
    input  logic                  hall_req_up,
    output logic [FW-1:0]         floor,
    output logic [1:0]            dir,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] car_pending,
    output logic [NUM_FLOORS-1:0] hall_up_pending,
    output logic [NUM_FLOORS-1:0] hall_dn_pending,
    output logic                  req_err
);
    localparam int TW = TRAVEL_CYCLES > 1 ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DLOAD = DW'(DWELL_CYCLES - 1);
    localparam logic [FW:0] NMAX = (FW+1)'(NUM_FLOORS);
    localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
    localparam logic [1:0] D_IDLE = 2'b00, D_UP = 2'b01, D_DN = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t state_q, state_d;
    logic [FW-1:0] floor_q, floor_d, nf;
    logic [1:0] dir_q, dir_d, door_dir;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [NUM_FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d, all, car_set, up_set, dn_set;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic last_up_q, last_up_d, arr_stop_q, arr_stop_d, arr_halt_q, arr_halt_d, req_err_q, req_err_d;
    logic hi, lo, here, up_dir, dn_dir, ahead, behind, opp, mu, ahead_nf, stop_nf, halt_nf;
    logic car_bad, hall_bad, car_ok, hall_ok, car_here, hall_here, door_hit;
    logic go_door, go_up, go_dn, go_idle;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) if (i > int'(f)) r |= v[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) if (i < int'(f)) r |= v[i];
        return r;
    endfunction

    assign all    = car_q | up_q | dn_q;
    assign hi     = any_above(all, floor_q);
    assign lo     = any_below(all, floor_q);
    assign here   = all[floor_q];
    assign up_dir = dir_q == D_UP;
    assign dn_dir = dir_q == D_DN;
    assign ahead  = up_dir ? hi : (dn_dir ? lo : 1'b0);
    assign behind = up_dir ? lo : (dn_dir ? hi : 1'b0);
    assign opp    = dir_q == D_IDLE || !ahead;
    assign door_dir = (opp && behind) ? (up_dir ? D_DN : D_UP) : dir_q;

    // arrival decision for the floor the car is about to step onto
    assign mu       = state_q == MOVE_UP;
    assign nf       = mu ? floor_q + FW'(1) : floor_q - FW'(1);
    assign ahead_nf = mu ? any_above(all, nf) : any_below(all, nf);
    assign stop_nf  = car_q[nf] || (mu ? up_q[nf] : dn_q[nf]) || (!ahead_nf && all[nf]);
    assign halt_nf  = (mu ? nf == TOP : nf == '0) || !ahead_nf;

    assign car_bad   = {1'b0, car_req_floor} >= NMAX;
    assign hall_bad  = {1'b0, hall_req_floor} >= NMAX || (hall_req_up && hall_req_floor == TOP)
                    || (!hall_req_up && hall_req_floor == '0);
    assign car_ok    = car_req_valid && !car_bad;
    assign hall_ok   = hall_req_valid && !hall_bad;
    assign car_here  = car_ok && state_q == DOOR && car_req_floor == floor_q;
    assign hall_here = hall_ok && state_q == DOOR && hall_req_floor == floor_q
                    && (dir_q == D_IDLE || (hall_req_up ? up_dir : dn_dir));
    assign door_hit  = car_here || hall_here;
    assign car_set   = (car_ok && !car_here) ? ONE << car_req_floor : '0;
    assign up_set    = (hall_ok && !hall_here && hall_req_up) ? ONE << hall_req_floor : '0;
    assign dn_set    = (hall_ok && !hall_here && !hall_req_up) ? ONE << hall_req_floor : '0;
    assign req_err_d = (car_req_valid && car_bad) || (hall_req_valid && hall_bad);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d = dir_q;
        tcnt_d = tcnt_q;
        dcnt_d = dcnt_q;
        arr_stop_d = 1'b0;
        arr_halt_d = 1'b0;
        go_door = 1'b0;
        go_up = 1'b0;
        go_dn = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                go_door = here;
                go_up = !here && hi && (last_up_q || !lo);
                go_dn = !here && !go_up && lo;
            end
            MOVE_UP, MOVE_DOWN: begin
                go_door = arr_stop_q;
                go_idle = !arr_stop_q && arr_halt_q;
                if (!arr_stop_q && !arr_halt_q) begin
                    if (tcnt_q == '0) begin
                        floor_d = nf;
                        tcnt_d = TLOAD;
                        arr_stop_d = stop_nf;
                        arr_halt_d = halt_nf;
                    end else tcnt_d = tcnt_q - TW'(1);
                end
            end
            default: begin
                if (door_hit) dcnt_d = DLOAD;
                else if (dcnt_q != '0) dcnt_d = dcnt_q - DW'(1);
                else begin
                    go_up = (up_dir && hi) || (dn_dir && !lo && hi);
                    go_dn = (dn_dir && lo) || (up_dir && !hi && lo);
                    go_idle = !go_up && !go_dn;
                end
            end
        endcase
        if (go_door) begin
            state_d = DOOR;
            dcnt_d = DLOAD;
            dir_d = door_dir;
        end
        if (go_up || go_dn) begin
            state_d = go_up ? MOVE_UP : MOVE_DOWN;
            dir_d = go_up ? D_UP : D_DN;
            tcnt_d = TLOAD;
        end
        if (go_idle) begin
            state_d = IDLE;
            dir_d = D_IDLE;
        end
        last_up_d = dir_d == D_UP ? 1'b1 : (dir_d == D_DN ? 1'b0 : last_up_q);
        clr_car = go_door ? ONE << floor_q : '0;
        clr_up = (go_door && (up_dir || opp)) ? ONE << floor_q : '0;
        clr_dn = (go_door && (dn_dir || opp)) ? ONE << floor_q : '0;
        car_d = (car_q & ~clr_car) | car_set;
        up_d = (up_q & ~clr_up) | up_set;
        dn_d = (dn_q & ~clr_dn) | dn_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            floor_q <= FW'(RESET_FLOOR);
            dir_q <= D_IDLE;
            tcnt_q <= '0;
            dcnt_q <= '0;
            car_q <= '0;
            up_q <= '0;
            dn_q <= '0;
            last_up_q <= 1'b1;
            arr_stop_q <= 1'b0;
            arr_halt_q <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q <= dir_d;
            tcnt_q <= tcnt_d;
            dcnt_q <= dcnt_d;
            car_q <= car_d;
            up_q <= up_d;
            dn_q <= dn_d;
            last_up_q <= last_up_d;
            arr_stop_q <= arr_stop_d;
            arr_halt_q <= arr_halt_d;
            req_err_q <= req_err_d;
        end
    end

    assign floor = floor_q;
    assign dir = dir_q;
    assign door_open = state_q == DOOR;
    assign car_pending = car_q;
    assign hall_up_pending = up_q;
    assign hall_dn_pending = dn_q;
    assign req_err = req_err_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed table and sequence checks for elevator_ctrl (5 floors, travel 4, dwell 3)
module tb_elevator_ctrl;
    localparam int NF = 5;
    localparam int FW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic car_req_valid, hall_req_valid, hall_req_up;
    logic [FW-1:0] car_req_floor, hall_req_floor;
    logic [FW-1:0] floor;
    logic [1:0] dir;
    logic door_open, req_err;
    logic [NF-1:0] car_pending, hall_up_pending, hall_dn_pending;

    elevator_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(4), .DWELL_CYCLES(3), .RESET_FLOOR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .car_req_valid(car_req_valid), .car_req_floor(car_req_floor),
        .hall_req_valid(hall_req_valid), .hall_req_floor(hall_req_floor), .hall_req_up(hall_req_up),
        .floor(floor), .dir(dir), .door_open(door_open),
        .car_pending(car_pending), .hall_up_pending(hall_up_pending), .hall_dn_pending(hall_dn_pending),
        .req_err(req_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cv; logic [FW-1:0] cf;
        logic hv; logic [FW-1:0] hf; logic hu;
        logic err; logic [NF-1:0] car, up, dn;
    } vec_t;

    vec_t vt[10];
    int checks = 0;
    int errors = 0;
    int stop_f[$], stop_t[$], stop_d[$], stop_h[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        car_req_valid = 1'b0; car_req_floor = '0;
        hall_req_valid = 1'b0; hall_req_floor = '0; hall_req_up = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // records floor, cycle, dir and hall-down bit of each stop from cycle t0 to t1
    task automatic run_log(input int t0, input int t1);
        logic prev;
        prev = door_open;
        stop_f.delete(); stop_t.delete(); stop_d.delete(); stop_h.delete();
        for (int t = t0; t <= t1; t++) begin
            tick();
            if (door_open && !prev) begin
                stop_f.push_back(int'(floor)); stop_t.push_back(t);
                stop_d.push_back(int'(dir)); stop_h.push_back(int'(hall_dn_pending[floor]));
            end
            prev = door_open;
        end
    endtask

    initial begin
        int ef[3], et[3], ed[3];
        vt[0] = '{1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[1] = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[2] = '{1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[3] = '{1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[4] = '{1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[5] = '{1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000};
        vt[6] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000};
        vt[7] = '{1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 5'b01000, 5'b00010, 5'b00000};
        vt[8] = '{1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 5'b01000, 5'b00010, 5'b00000};
        vt[9] = '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 5'b01000, 5'b00010, 5'b00100};

        do_reset();
        chk("reset floor", int'(floor), 0);
        chk("reset dir", int'(dir), 0);
        chk("reset door", int'(door_open), 0);
        chk("reset err", int'(req_err), 0);
        chk("reset pending", int'({car_pending, hall_up_pending, hall_dn_pending}), 0);

        for (int i = 0; i < 10; i++) begin
            car_req_valid = vt[i].cv; car_req_floor = vt[i].cf;
            hall_req_valid = vt[i].hv; hall_req_floor = vt[i].hf; hall_req_up = vt[i].hu;
            tick();
            chk($sformatf("vec%0d req_err", i), int'(req_err), int'(vt[i].err));
            chk($sformatf("vec%0d car", i), int'(car_pending), int'(vt[i].car));
            chk($sformatf("vec%0d up", i), int'(hall_up_pending), int'(vt[i].up));
            chk($sformatf("vec%0d dn", i), int'(hall_dn_pending), int'(vt[i].dn));
        end
        idle_in();
        tick();
        chk("err single pulse", int'(req_err), 0);

        // single car call to floor 3
        do_reset();
        car_req_valid = 1'b1; car_req_floor = 3'd3;
        tick();
        idle_in();
        chk("s1 pending t1", int'(car_pending), 5'b01000);
        for (int t = 2; t <= 18; t++) begin
            tick();
            chk($sformatf("s1 floor t%0d", t), int'(floor), t < 6 ? 0 : t < 10 ? 1 : t < 14 ? 2 : 3);
            chk($sformatf("s1 door t%0d", t), int'(door_open), (t >= 15 && t <= 17) ? 1 : 0);
            chk($sformatf("s1 dir t%0d", t), int'(dir), (t >= 2 && t <= 17) ? 1 : 0);
            if (t == 15) chk("s1 car cleared", int'(car_pending), 0);
        end

        // car calls 2 and 4 plus hall down at 3
        do_reset();
        car_req_valid = 1'b1; car_req_floor = 3'd2;
        hall_req_valid = 1'b1; hall_req_floor = 3'd3; hall_req_up = 1'b0;
        tick();
        idle_in();
        car_req_valid = 1'b1; car_req_floor = 3'd4;
        tick();
        idle_in();
        run_log(3, 40);
        ef = '{2, 4, 3}; et = '{11, 23, 31}; ed = '{1, 2, 2};
        chk("s2 stop count", stop_f.size(), 3);
        for (int i = 0; i < 3 && i < stop_f.size(); i++) begin
            chk($sformatf("s2 stop%0d floor", i), stop_f[i], ef[i]);
            chk($sformatf("s2 stop%0d time", i), stop_t[i], et[i]);
            chk($sformatf("s2 stop%0d dir", i), stop_d[i], ed[i]);
            chk($sformatf("s2 stop%0d hall_dn", i), stop_h[i], 0);
        end
        chk("s2 final dir", int'(dir), 0);

        // hall down at 2 is passed on the way up
        do_reset();
        car_req_valid = 1'b1; car_req_floor = 3'd4;
        hall_req_valid = 1'b1; hall_req_floor = 3'd2; hall_req_up = 1'b0;
        tick();
        idle_in();
        run_log(2, 40);
        ef = '{4, 2, 0}; et = '{19, 31, 0};
        chk("s3 stop count", stop_f.size(), 2);
        for (int i = 0; i < 2 && i < stop_f.size(); i++) begin
            chk($sformatf("s3 stop%0d floor", i), stop_f[i], ef[i]);
            chk($sformatf("s3 stop%0d time", i), stop_t[i], et[i]);
            chk($sformatf("s3 stop%0d dir", i), stop_d[i], 2);
        end
        chk("s3 hall_dn empty", int'(hall_dn_pending), 0);

        // car call at the open floor reloads dwell
        do_reset();
        car_req_valid = 1'b1; car_req_floor = 3'd2;
        tick();
        idle_in();
        for (int t = 2; t <= 11; t++) tick();
        chk("s5 door at 11", int'(door_open), 1);
        chk("s5 floor at 11", int'(floor), 2);
        tick();
        car_req_valid = 1'b1; car_req_floor = 3'd2;
        tick();
        idle_in();
        chk("s5 not latched", int'(car_pending), 0);
        chk("s5 door at 13", int'(door_open), 1);
        tick();
        tick();
        chk("s5 door at 15", int'(door_open), 1);
        tick();
        chk("s5 door at 16", int'(door_open), 0);

        // reset mid-travel
        do_reset();
        car_req_valid = 1'b1; car_req_floor = 3'd4;
        hall_req_valid = 1'b1; hall_req_floor = 3'd1; hall_req_up = 1'b0;
        tick();
        idle_in();
        for (int t = 2; t <= 11; t++) tick();
        chk("s6 floor before reset", int'(floor), 2);
        rst_n = 1'b0;
        #1;
        chk("s6 async floor", int'(floor), 0);
        chk("s6 async pending", int'({car_pending, hall_up_pending, hall_dn_pending}), 0);
        tick();
        chk("s6 floor", int'(floor), 0);
        chk("s6 dir", int'(dir), 0);
        chk("s6 door", int'(door_open), 0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("s6 no resume floor", int'(floor), 0);
        chk("s6 no resume dir", int'(dir), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised single-car elevator controller for the Lab 2 elevator design. It generalises the fixed five-floor controller to NUM_FLOORS floors, with programmable travel and door-dwell timing. It latches car (inside) and hall (outside up/down) calls into pending vectors and serves them with a collective-selective (SCAN) policy. Floor index, direction and door status feed the board's seven-segment and LED drivers.

## Interface
- NUM_FLOORS, 5: number of floors, minimum 2; floors are 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 13000000: clock cycles to move one floor, minimum 1.
- DWELL_CYCLES, 13000000: clock cycles the door stays open, minimum 1.
- RESET_FLOOR, 0: floor the car occupies after reset.
- FW (local), $clog2(NUM_FLOORS): floor index width.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- car_req_valid  in  1  a car-call strobe, sampled each cycle.
- car_req_floor  in  FW  the requested floor for the car call.
- hall_req_valid  in  1  a hall-call strobe.
- hall_req_floor  in  FW  the floor the hall call is made from.
- hall_req_up  in  1  hall-call direction; 1 = up, 0 = down.
- floor  out  FW  the current car floor.
- dir  out  2  direction: 00 idle, 01 up, 10 down.
- door_open  out  1  high while the car is in DOOR.
- car_pending  out  NUM_FLOORS  latched car calls.
- hall_up_pending, hall_dn_pending  out  NUM_FLOORS each  latched hall calls.
- req_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. dir reads 01 in MOVE_UP and 10 in MOVE_DOWN. In IDLE it reads 00. In DOOR it holds the last travel direction.
- A "matching" request at floor f means car_pending[f], or the hall bit at f for the current direction.
- Request latching:
  - A valid strobe sets its pending bit at the same edge.
  - Car and hall strobes in the same cycle are both latched.
  - A strobe whose bit is already set has no effect.
- Rejection: req_err pulses and nothing is latched when the floor is ≥ NUM_FLOORS, for a hall up call at the top floor, and for a hall down call at floor 0. If both strobes are bad in one cycle, req_err still pulses only once.
- Request at the current floor during DOOR: a car call, or a hall call matching dir (either direction when dir = 00), is not latched. Instead it reloads the dwell counter.
- IDLE:
  - If any pending bit is set at floor, go to DOOR.
  - Otherwise, if any request exists above floor and (the last travel direction was up or nothing is below), go to MOVE_UP.
  - Otherwise, if anything is below, go to MOVE_DOWN.
  - Otherwise stay in IDLE.
- MOVE_x:
  - The travel counter loads TRAVEL_CYCLES-1 on entry and counts to 0.
  - At 0, floor is incremented (up) or decremented (down).
  - Stop (go to DOOR) if the new floor has a matching request, or if nothing is ahead and any request exists at the new floor.
  - Otherwise reload the counter and continue.
  - The car never moves past floor 0 or NUM_FLOORS-1. Reaching an end floor with nothing pending there goes to IDLE.
- DOOR:
  - On entry, clear car_pending[floor] and the hall bit for dir at floor.
  - If dir = 00, or no requests lie ahead, also clear the opposite hall bit and set dir to the opposite direction when requests lie behind.
  - The dwell counter counts DWELL_CYCLES cycles.
  - At expiry: requests ahead go to MOVE in the same direction; otherwise requests behind go to MOVE in the opposite direction; otherwise go to IDLE.
- All arithmetic is unsigned on FW bits. Counters are sized by $clog2 of their parameter.

## Timing
- Reset values: floor = RESET_FLOOR, dir = 00, door_open = 0, all pending vectors = 0, req_err = 0, state = IDLE, counters = 0.
- Reset asserted mid-move or mid-dwell aborts immediately; nothing resumes after reset is released.
- A request strobed in cycle t shows its pending bit in cycle t+1.
- From IDLE, the state changes at the end of cycle t+1, so dir or door_open is visible from cycle t+2.
- floor changes exactly TRAVEL_CYCLES cycles after MOVE entry, and every TRAVEL_CYCLES cycles after that while moving.
- The stop/continue decision is registered at the same edge as the floor update, so DOOR starts the cycle after the new floor appears.
- door_open is high for exactly DWELL_CYCLES cycles per stop, plus any reloads. The next state follows at the edge after expiry.
- Pending-bit clears take effect on the first DOOR cycle.

## Test plan
All scenarios use NUM_FLOORS=5, TRAVEL_CYCLES=4, DWELL_CYCLES=3.
- Reset at floor 0, then car call to floor 3 at t=0 → dir=01 at t=2; floor steps to 1, 2, 3 at t=6, 10, 14; door_open for t=15..17; IDLE with dir=00 from t=18.
- Car at 0 with car calls 2 and 4, plus hall down at 3 → stops at 2 then 4; stops at 3 while moving down; hall_dn_pending[3] clears at that stop.
- Car passing floor 2 moving up with hall_dn_pending[2]=1 and car call 4 → no stop at 2; stops at 4; stops at 2 on the way down.
- hall_req_up with floor 4, hall down with floor 0, and car floor 7 → req_err pulses each time; pending vectors unchanged.
- During DOOR at floor 2, car call to floor 2 → not latched; door_open lasts 3 more cycles from the strobe.
- Assert rst_n=0 mid-travel at floor 2 with calls pending → next edge shows floor=0, all pending=0, dir=00, door_open=0.
